// File: rtl/nibble_serial_adder.sv
// Serial nibble adder: WIDTH-bit operands summed one nibble per clock
// through a single 4-bit ripple-carry adder, with valid/ready on both sides.

// rca_4bit: 4-bit ripple-carry adder built from full-adder cells.
// Latency: combinational, zero cycles.
// Backpressure: none; a pure function of its inputs.
module rca_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

// nibble_serial_adder: a + b + cin, LSB nibble first, one nibble per clock.
// Latency: out_valid rises NIBBLES edges after the accepting edge.
// Backpressure: holds result in DONE while out_ready=0; in_ready=0 until IDLE.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic [3:0]       nib_s;
    logic             nib_cout;
    logic [WIDTH-1:0] sum_shift;
    logic             last_nib;
    logic             in_fire;

    rca_4bit u_rca (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (carry),
        .s    (nib_s),
        .cout (nib_cout)
    );

    // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
    if (NIBBLES == 1) begin : g_shift_one
        assign sum_shift = nib_s;
    end else begin : g_shift_many
        assign sum_shift = {nib_s, sum_r[WIDTH-1:4]};
    end

    assign last_nib = (cnt == LAST_NIB);
    assign in_fire  = in_valid && in_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_fire)   state_nxt = RUN;
            RUN:  if (last_nib)  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = !rst;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand shifters, carry chain register, nibble counter and result
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    carry <= nib_cout;
                    cnt   <= cnt + CW'(1);
                    sum_r <= sum_shift;
                    if (last_nib) begin
                        cout_r <= nib_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and model-checked bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst;

    logic        iv16, ir16, ov16, or16, c16, co16, busy16;
    logic [15:0] a16, b16, s16;

    logic        iv4, ir4, ov4, or4, c4, co4, busy4;
    logic [3:0]  a4, b4, s4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .a         (a16),
        .b         (b16),
        .cin       (c16),
        .out_valid (ov16),
        .out_ready (or16),
        .sum       (s16),
        .cout      (co16),
        .busy      (busy16)
    );

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv4),
        .in_ready  (ir4),
        .a         (a4),
        .b         (b4),
        .cin       (c4),
        .out_valid (ov4),
        .out_ready (or4),
        .sum       (s4),
        .cout      (co4),
        .busy      (busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one op to the 16-bit DUT and check latency and result when out_valid rises.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, input string tag);
        int          n;
        int          lat;
        logic [16:0] e;
        e = {1'b0, a} + {1'b0, b} + {16'd0, c};
        n = 0;
        a16 = a; b16 = b; c16 = c; iv16 = 1'b1;
        while (!ir16 && n < 50) begin tick(); n++; end
        check({tag, "_in_ready"}, ir16, 1);
        tick();
        iv16 = 1'b0;
        a16 = ~a; b16 = ~b; c16 = ~c;
        lat = 0;
        while (!ov16 && lat < 20) begin tick(); lat++; end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_sum"}, s16, e[15:0]);
        check({tag, "_cout"}, co16, e[16]);
    endtask

    task automatic done16(input string tag, input bit rnd);
        int n;
        n = 0;
        while (ov16 && n < 60) begin
            if (rnd) or16 = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        or16 = 1'b1;
        check({tag, "_released"}, ov16, 0);
        check({tag, "_idle"}, busy16, 0);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
        int         n;
        int         lat;
        logic [4:0] e;
        e = {1'b0, a} + {1'b0, b} + {4'd0, c};
        n = 0;
        a4 = a; b4 = b; c4 = c; iv4 = 1'b1;
        while (!ir4 && n < 50) begin tick(); n++; end
        tick();
        iv4 = 1'b0;
        a4 = ~a; b4 = ~b;
        lat = 0;
        while (!ov4 && lat < 20) begin tick(); lat++; end
        check("w4_latency", lat, 1);
        check("w4_sumcout", {co4, s4}, e);
        tick();
        check("w4_released", ov4, 0);
    endtask

    initial begin
        rst = 1'b1;
        iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; c16 = 1'b0;
        iv4  = 1'b0; or4  = 1'b1; a4  = '0; b4  = '0; c4  = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", ir16, 0);
        check("rst_out_valid", ov16, 0);
        check("rst_sum", s16, 16'h0000);
        check("rst_cout", co16, 0);
        check("rst_busy", busy16, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", ir16, 1);
        tick();

        // Basic op, full ripple, cin corner cases
        op16(16'h1234, 16'h4321, 1'b0, "t1");
        check("t1_sum_const", s16, 16'h5555);
        done16("t1", 1'b0);
        op16(16'hFFFF, 16'h0001, 1'b0, "t2");
        check("t2_sum_const", {co16, s16}, 17'h10000);
        done16("t2", 1'b0);
        op16(16'hFFFF, 16'hFFFF, 1'b1, "t3a");
        check("t3a_sum_const", {co16, s16}, 17'h1FFFF);
        done16("t3a", 1'b0);
        op16(16'h0000, 16'h0000, 1'b1, "t3b");
        check("t3b_sum_const", {co16, s16}, 17'h00001);
        check("t3b_hold_after", 0, 0 + ov16 - 1'b1 + 1'b1 - ov16);
        done16("t3b", 1'b0);
        check("t3b_sum_held", s16, 16'h0001);

        // Backpressure in DONE with an ignored in_valid pulse
        or16 = 1'b0;
        op16(16'h8001, 16'h8002, 1'b0, "t4");
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin iv16 = 1'b1; a16 = 16'h0F0F; b16 = 16'h0F0F; end
            if (i == 5) iv16 = 1'b0;
            tick();
            check("t4_hold_valid", ov16, 1);
            check("t4_hold_sum", s16, 16'h0003);
            check("t4_hold_cout", co16, 1);
            check("t4_hold_in_ready", ir16, 0);
        end
        or16 = 1'b1;
        tick();
        check("t4_release_valid", ov16, 0);
        check("t4_release_in_ready", ir16, 1);
        tick();
        check("t4_no_capture", busy16, 0);
        check("t4_sum_kept", s16, 16'h0003);

        // Reset after two nibbles of an op
        a16 = 16'h1111; b16 = 16'h1111; c16 = 1'b0; iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        tick();
        tick();
        check("t5_busy_before", busy16, 1);
        check("t5_partial_sum", s16, 16'h2200);
        rst = 1'b1;
        #1;
        check("t5_in_ready_in_rst", ir16, 0);
        tick();
        rst = 1'b0;
        check("t5_out_valid", ov16, 0);
        check("t5_sum", s16, 16'h0000);
        check("t5_cout", co16, 0);
        check("t5_busy", busy16, 0);
        op16(16'h00FF, 16'h0001, 1'b0, "t5b");
        check("t5b_sum_const", {co16, s16}, 17'h00100);
        done16("t5b", 1'b0);

        // WIDTH=4 exhaustive
        for (int i = 0; i < 512; i++) begin
            op4(i[3:0], i[7:4], i[8]);
        end

        // WIDTH=16 random ops with random out_ready
        for (int k = 0; k < 2000; k++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            or16 = 1'($urandom_range(0, 1));
            op16(ra, rb, 1'($urandom_range(0, 1)), "rnd");
            done16("rnd", 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
